cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Upstream stage of the multicycle CPU. Turns the raw step key and run switch into a one-cycle CPU step-enable, `cpu_step_en`.
- Each pulse advances the control FSM and all CPU registers by exactly one state.
- Provides debounced manual stepping, a free-run mode at a divided rate, and a PC breakpoint.
- Also provides a step counter for the debug displays.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the key must hold a new level before it is accepted (10 ms at 50 MHz).
- RUN_DIV, 5000000: clock cycles between step pulses in run mode (10 Hz).
- CNT_W, 16: width of step_count.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- key_step  in  1  raw step key, already inverted to active-high; asynchronous to clock.
- sw_run  in  1  1 = free-run mode, 0 = manual step mode; asynchronous.
- bp_en  in  1  enable the breakpoint compare.
- bp_addr  in  8  breakpoint PC value.
- pc  in  8  current CPU program counter.
- fetch_state  in  1  high while the CPU FSM is in its instruction-fetch state.
- cpu_step_en  out  1  one-cycle step pulse to the CPU.
- running  out  1  high in the RUN state.
- halted_bp  out  1  high in the BREAK state.
- step_count  out  CNT_W  number of pulses issued since reset; wraps.

Behaviour:
- Reset: synchronous and active-high, taking effect at the rising clock edge. Reset mid-operation aborts any pending pulse in that cycle. All outputs are 0 the cycle after reset. State = IDLE, all counters = 0, debounced key level = 0.
- Synchronisers: key_step and sw_run each pass through a 2-flop synchroniser.
- Debounce:
  - A counter increments while the synchronised key differs from the accepted level.
  - It clears to 0 when they match.
  - When it reaches DEBOUNCE_CYCLES-1, the accepted level toggles and the counter clears.
  - press = one-cycle pulse on the 0->1 transition of the accepted level. Releases produce nothing.
- State machine (IDLE, RUN, BREAK):
  - IDLE:
    - press -> cpu_step_en=1 for exactly that cycle; stay in IDLE.
    - synchronised sw_run=1 -> go to RUN, div counter=0.
  - RUN:
    - Div counter counts 0..RUN_DIV-1; cpu_step_en=1 in the cycle it equals RUN_DIV-1, then it wraps to 0.
    - Presses are ignored.
    - sw_run=0 -> IDLE; no pulse is issued that cycle.
  - BREAK:
    - No pulses while sw_run=1 and no press.
    - press -> one pulse, then return to RUN with div counter=0.
    - sw_run=0 -> IDLE.
- Breakpoint check (RUN only): in a cycle where RUN would emit a pulse and bp_en=1 and pc==bp_addr and fetch_state=1, enter BREAK instead. The pulse is suppressed and the CPU halts before fetching the instruction at bp_addr.
- Simultaneous events: sw_run falling has priority over both press and breakpoint. The breakpoint has priority over the run pulse.
- Minimum pulse spacing: cpu_step_en is never high on two consecutive cycles. RUN_DIV >= 2 is required, and both press pulses are one cycle wide.
- step_count: increments by 1 on every cycle with cpu_step_en=1 and wraps from 2^CNT_W-1 to 0.
- Output sources:
  - running and halted_bp decode directly from the state register.
  - cpu_step_en is registered (one cycle after the qualifying condition).

Optional Feature:
- Macro CPU_STEP_BP_EN.
- Defined: breakpoint behaviour as above.
- Undefined: no comparator logic; the BREAK state is unreachable; halted_bp is tied to 0. Port list is unchanged; bp_en, bp_addr, pc and fetch_state are ignored.

Decomposition:
- Package cpu_step_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, BREAK=2'd2) and the default values of DEBOUNCE_CYCLES and RUN_DIV.
- One sub-module, key_debounce: 2-flop synchroniser, debounce counter, accepted level and press pulse. Parameterised by DEBOUNCE_CYCLES and instantiated once for key_step.
- sw_run uses only a bare 2-flop synchroniser.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=4):
- Reset: hold reset for 2 cycles with key_step=1 and sw_run=1 -> all outputs 0 and state IDLE on release; the first pulse appears only after a full debounce/run sequence.
- Bounce: key_step toggles 1,0,1,0 at 1-cycle spacing, then stays 1 for 8 cycles -> exactly one cpu_step_en pulse, about 6 cycles after the stable edge; step_count=1.
- Run: sw_run=1 for 20 cycles -> pulses exactly every 3 cycles; step_count increments per pulse; running=1. Drop sw_run -> no further pulses 3 cycles after the drop.
- Breakpoint (CPU_STEP_BP_EN defined): bp_en=1, bp_addr=8'h05, drive pc=8'h05 with fetch_state=1 at a RUN pulse slot -> no pulse; halted_bp=1 and stays 1. A debounced press -> one pulse, then RUN resumes.
- Wrap and priority: issue 16 pulses -> step_count wraps 4'hF to 4'h0. In RUN, drop sw_run in the same cycle as a breakpoint match -> IDLE, halted_bp stays 0, no pulse.
- Macro undefined: repeat the breakpoint scenario -> pulses continue every 3 cycles; halted_bp is never 1.

Source files
------------

// File: rtl/cpu_step_pkg.sv
// cpu_step_pkg: shared definitions for the CPU step controller.
//   state_e                 - controller state encoding (IDLE / RUN / BREAK)
//   DEBOUNCE_CYCLES_DEF     - default key debounce time (10 ms at 50 MHz)
//   RUN_DIV_DEF             - default free-run step period (10 Hz at 50 MHz)
package cpu_step_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BREAK = 2'd2
  } state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 500000;
  localparam int RUN_DIV_DEF         = 5000000;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser + debouncer for one raw key.
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high reset
//   key_i    in   raw key level (active-high), asynchronous to clock
//   press_o  out  one-cycle pulse when the accepted level rises 0->1
// The synchronised key must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before the accepted level flips.
module key_debounce
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          toggle;

  // Flip on the last cycle of a full disagreement run.
  assign toggle  = (s2_q != lvl_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  // Press fires in the same cycle the level is about to rise, so the
  // registered step pulse downstream lands one cycle later.
  assign press_o = toggle & ~lvl_q;

  always_comb begin
    lvl_d = lvl_q ^ toggle;
    cnt_d = cnt_q + CW'(1);
    if ((s2_q == lvl_q) || toggle) cnt_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= key_i;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: generates the one-cycle CPU step enable from a debounced
// step key (manual mode) or a divided clock (free-run mode), with an
// optional PC breakpoint that halts free-run before fetching bp_addr.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   key_step       raw step key (active-high, async)
//   sw_run         1 = free-run, 0 = manual step (async)
//   bp_en, bp_addr breakpoint enable and PC value
//   pc, fetch_state current CPU PC, high in the CPU fetch state
//   cpu_step_en    registered one-cycle step pulse
//   running        state is RUN
//   halted_bp      state is BREAK
//   step_count     pulses issued since reset (wraps)
// Build option: define CPU_STEP_BP_EN to include the breakpoint comparator.
// Without it BREAK is unreachable, halted_bp is 0 and the breakpoint
// inputs are ignored.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int RUN_DIV         = RUN_DIV_DEF,
  parameter int CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_step,
  input  logic             sw_run,
  input  logic             bp_en,
  input  logic [7:0]       bp_addr,
  input  logic [7:0]       pc,
  input  logic             fetch_state,
  output logic             cpu_step_en,
  output logic             running,
  output logic             halted_bp,
  output logic [CNT_W-1:0] step_count
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_s1_q, run_s2_q;
  logic             press;
  logic             bp_hit;
  logic             div_end;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clock  (clock),
    .reset  (reset),
    .key_i  (key_step),
    .press_o(press)
  );

`ifdef CPU_STEP_BP_EN
  assign bp_hit    = bp_en && (pc == bp_addr) && fetch_state;
  assign halted_bp = (state_q == BREAK);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr, pc, fetch_state};
  assign bp_hit    = 1'b0;
  assign halted_bp = 1'b0;
`endif

  assign div_end = (div_q == DW'(RUN_DIV - 1));

  // sw_run low wins over press and breakpoint; breakpoint wins over
  // the run pulse (the pulse is swallowed and BREAK entered instead).
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    en_d    = 1'b0;
    case (state_q)
      IDLE: begin
        en_d = press;
        if (run_s2_q) begin
          state_d = RUN;
          div_d   = '0;
        end
      end
      RUN: begin
        if (!run_s2_q) begin
          state_d = IDLE;
        end else if (div_end) begin
          div_d = '0;
          if (bp_hit) state_d = BREAK;
          else        en_d    = 1'b1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      BREAK: begin
        if (!run_s2_q) begin
          state_d = IDLE;
        end else if (press) begin
          en_d    = 1'b1;
          state_d = RUN;
          div_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      en_q     <= 1'b0;
      cnt_q    <= '0;
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      en_q     <= en_d;
      cnt_q    <= cnt_q + CNT_W'(en_q);
      run_s1_q <= sw_run;
      run_s2_q <= run_s1_q;
    end
  end

  assign cpu_step_en = en_q;
  assign running     = (state_q == RUN);
  assign step_count  = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=3, CNT_W=4).
// Each expected pulse (cycle number and step_count at that cycle) is queued
// when the stimulus is driven; a negedge monitor pops and compares on every
// observed pulse, and flags pulses nobody asked for.
module tb_cpu_step_ctrl;

`ifdef CPU_STEP_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, key_step, sw_run, bp_en, fetch_state;
  logic [7:0] bp_addr, pc;
  logic       cpu_step_en, running, halted_bp;
  logic [3:0] step_count;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       q[$];
  logic [3:0] exp_cnt = 4'd0;
  int         cyc = 0;
  int         n_chk = 0, n_pass = 0, n_fail = 0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (3),
    .CNT_W          (4)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .key_step   (key_step),
    .sw_run     (sw_run),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .fetch_state(fetch_state),
    .cpu_step_en(cpu_step_en),
    .running    (running),
    .halted_bp  (halted_bp),
    .step_count (step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c);
    q.push_back('{c, exp_cnt});
    exp_cnt = exp_cnt + 4'd1;
  endtask

  always @(negedge clk) begin
    if (cpu_step_en === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_pulse_qsize", q.size(), 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("pulse_step_count", int'(step_count), int'(e.cnt));
      end
    end
  end

  initial begin
    int cs, start;
    reset = 1'b1; key_step = 1'b1; sw_run = 1'b1;
    bp_en = 1'b0; bp_addr = 8'h05; pc = 8'h00; fetch_state = 1'b1;

    // Reset held with key and run asserted: outputs stay clear.
    step(2);
    chk("rst_step_en", int'(cpu_step_en), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_halted",  int'(halted_bp), 0);
    chk("rst_count",   int'(step_count), 0);
    reset = 1'b0;
    cs = cyc;
    push(cs + 6);               // first run pulse; the key press is ignored in RUN
    step(4);
    chk("rst_run_entered", int'(running), 1);
    step(2);
    sw_run = 1'b0; key_step = 1'b0;
    step(14);
    chk("rst_drain", q.size(), 0);
    chk("rst_idle", int'(running), 0);
    chk("rst_count_after", int'(step_count), int'(exp_cnt));

    // Bouncing key then a stable press: exactly one pulse.
    key_step = 1'b1; step(1); key_step = 1'b0; step(1);
    key_step = 1'b1; step(1); key_step = 1'b0; step(1);
    key_step = 1'b1;
    cs = cyc;
    push(cs + 6);
    step(8);
    chk("bounce_drain", q.size(), 0);
    chk("bounce_count", int'(step_count), int'(exp_cnt));
    key_step = 1'b0;
    step(14);

    // Free run for 20 cycles with a key press that must be ignored.
    cs = cyc;
    sw_run = 1'b1;
    for (int t = cs + 6; t <= cs + 22; t += 3) push(t);
    step(5);
    key_step = 1'b1;
    step(5);
    chk("run_running", int'(running), 1);
    step(10);
    sw_run = 1'b0; key_step = 1'b0;
    step(14);
    chk("run_drain", q.size(), 0);
    chk("run_stopped", int'(running), 0);
    chk("run_count", int'(step_count), int'(exp_cnt));

    // Breakpoint at pc=5 after the first run pulse, then a press resumes.
    bp_en = 1'b1; pc = 8'h00;
    cs = cyc;
    sw_run = 1'b1;
    if (BP) begin
      push(cs + 6); push(cs + 23); push(cs + 26); push(cs + 29);
    end else begin
      for (int t = cs + 6; t <= cs + 31; t += 3) push(t);
    end
    step(6);
    pc = 8'h05;
    step(6);
    chk("bp_halted", int'(halted_bp), BP ? 1 : 0);
    chk("bp_running", int'(running), BP ? 0 : 1);
    step(5);
    chk("bp_halted_hold", int'(halted_bp), BP ? 1 : 0);
    key_step = 1'b1; pc = 8'h00;
    step(8);
    chk("bp_resumed", int'(running), 1);
    chk("bp_released", int'(halted_bp), 0);
    step(4);
    sw_run = 1'b0; key_step = 1'b0;
    step(14);
    chk("bp_drain", q.size(), 0);
    chk("bp_count", int'(step_count), int'(exp_cnt));

    // sw_run drop lands on the same cycle as a breakpoint match.
    pc = 8'h05;
    cs = cyc;
    sw_run = 1'b1;
    step(3);
    sw_run = 1'b0;
    step(1);
    chk("prio_running", int'(running), 1);
    step(3);
    chk("prio_idle", int'(running), 0);
    chk("prio_not_halted", int'(halted_bp), 0);
    step(8);
    chk("prio_drain", q.size(), 0);

    // 16 pulses: step_count wraps through 4'hF back to its start value.
    bp_en = 1'b0; pc = 8'h00;
    start = int'(exp_cnt);
    cs = cyc;
    sw_run = 1'b1;
    for (int t = cs + 6; t <= cs + 51; t += 3) push(t);
    step(49);
    sw_run = 1'b0;
    step(10);
    chk("wrap_drain", q.size(), 0);
    chk("wrap_count", int'(step_count), start);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
